// File: rtl/px_ss_csr_pkg.sv
// Shared constants and types for the pixel-subsampler CSR block.
// Register slot offsets, status bit positions, AXI response codes and the address decode record.
package px_ss_csr_pkg;

    localparam int REGS_PER_CH = 8;
    localparam int NUM_CR      = 6;
    localparam int CH_BYTES    = REGS_PER_CH * 4;
    localparam int CH_SHIFT    = 5;
    localparam int SLOT_SHIFT  = 2;

    typedef enum logic [2:0] {
        SLOT_PX_SKIP        = 3'd0,
        SLOT_PX_INTERVAL    = 3'd1,
        SLOT_PX_ADD_INTERVAL = 3'd2,
        SLOT_LN_SKIP        = 3'd3,
        SLOT_LN_INTERVAL    = 3'd4,
        SLOT_LN_ADD_INTERVAL = 3'd5,
        SLOT_STATUS         = 3'd6,
        SLOT_RSVD           = 3'd7
    } slot_e;

    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_FCNT_LSB    = 16;
    localparam int FCNT_W             = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic       hit;
        logic [3:0] ch;
        logic [2:0] slot;
    } dec_t;

    function automatic logic is_cr_slot(input logic [2:0] slot);
        return slot < 3'(NUM_CR);
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// 32-bit AXI4-Lite bus bundle with master and slave views.
// Every channel transfers on a clock edge where its valid and ready are both high;
// valid never waits on ready and payload stays stable while valid is high.
interface axi4_lite_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/px_ss_csr_ch.sv
// One channel's register bank: config registers, pending flag, frame counter and read mux.
// With PX_SS_CSR_SHADOW_EN defined, writes land in shadow registers applied on sof.
module px_ss_csr_ch
    import px_ss_csr_pkg::*;
#(
    parameter int CR_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we,
    input  logic [2:0]      wr_slot,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            sof,
    input  logic [2:0]      rd_slot,
    output logic [31:0]     rdata,
    output logic [CR_W-1:0] px_to_skip,
    output logic [CR_W-1:0] px_skip_interval,
    output logic [CR_W-1:0] add_px_skip_interval,
    output logic [CR_W-1:0] ln_to_skip,
    output logic [CR_W-1:0] ln_skip_interval,
    output logic [CR_W-1:0] add_ln_skip_interval
);

    logic [NUM_CR-1:0][CR_W-1:0] active_q;
    logic [NUM_CR-1:0][CR_W-1:0] cr_rd;
    logic [CR_W-1:0]             cur;
    logic [CR_W-1:0]             merged;
    logic [FCNT_W-1:0]           fcnt_q;
    logic                        pending;
    logic                        cr_we;

    // Strobe bits for bytes above CR_W and data bits above CR_W are dropped on purpose.
    logic unused_wbits;
    assign unused_wbits = ^{wdata, wstrb};

    assign cr_we = we && is_cr_slot(wr_slot);

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_CR; i++) begin
            if (wr_slot == 3'(i)) cur = cr_rd[i];
        end
        merged = cur;
        for (int b = 0; b < CR_W; b++) begin
            if (wstrb[b/8]) merged[b] = wdata[b];
        end
    end

`ifdef PX_SS_CSR_SHADOW_EN
    logic [NUM_CR-1:0][CR_W-1:0] shadow_q;
    logic                        pending_q;

    // sof copies the pre-write shadow; a simultaneous write stays pending for the next frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            if (sof) active_q <= shadow_q;
            if (cr_we) begin
                shadow_q[wr_slot] <= merged;
                pending_q         <= 1'b1;
            end else if (sof) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign cr_rd   = shadow_q;
    assign pending = pending_q;
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= '0;
        end else if (cr_we) begin
            active_q[wr_slot] <= merged;
        end
    end

    assign cr_rd   = active_q;
    assign pending = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) fcnt_q <= '0;
        else if (sof) fcnt_q <= fcnt_q + 1'b1;
    end

    always_comb begin
        rdata = '0;
        if (is_cr_slot(rd_slot)) begin
            for (int i = 0; i < NUM_CR; i++) begin
                if (rd_slot == 3'(i)) rdata = 32'(cr_rd[i]);
            end
        end else if (rd_slot == SLOT_STATUS) begin
            rdata[STATUS_FCNT_LSB +: FCNT_W] = fcnt_q;
            rdata[STATUS_PENDING_BIT]        = pending;
        end
    end

    assign px_to_skip           = active_q[SLOT_PX_SKIP];
    assign px_skip_interval     = active_q[SLOT_PX_INTERVAL];
    assign add_px_skip_interval = active_q[SLOT_PX_ADD_INTERVAL];
    assign ln_to_skip           = active_q[SLOT_LN_SKIP];
    assign ln_skip_interval     = active_q[SLOT_LN_INTERVAL];
    assign add_ln_skip_interval = active_q[SLOT_LN_ADD_INTERVAL];

endmodule

// File: rtl/px_ss_csr_mc.sv
// Multi-channel AXI4-Lite CSR block for the pixel subsampler: handshakes, holding buffers, decode.
// Optional shadow registers are enabled with the PX_SS_CSR_SHADOW_EN macro.
module px_ss_csr_mc
    import px_ss_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CH_CNT    = 1,
    parameter int          CR_W      = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    axi4_lite_if.slave             csr_i,
    input  logic [CH_CNT-1:0]      sof_i,
    output logic [CH_CNT*CR_W-1:0] px_to_skip_o,
    output logic [CH_CNT*CR_W-1:0] px_skip_interval_o,
    output logic [CH_CNT*CR_W-1:0] add_px_skip_interval_o,
    output logic [CH_CNT*CR_W-1:0] ln_to_skip_o,
    output logic [CH_CNT*CR_W-1:0] ln_skip_interval_o,
    output logic [CH_CNT*CR_W-1:0] add_ln_skip_interval_o
);

    localparam logic [31:0] WIN_BYTES = 32'(CH_CNT * CH_BYTES);

    function automatic dec_t decode(input logic [31:0] addr);
        dec_t d;
        d.hit  = (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < WIN_BYTES);
        d.ch   = 4'((addr - BASE_ADDR) >> CH_SHIFT);
        d.slot = 3'((addr - BASE_ADDR) >> SLOT_SHIFT);
        return d;
    endfunction

    logic        aw_full_q, w_full_q;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic        bvalid_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;

    logic              commit, ar_hs;
    dec_t              wr_dec, rd_dec;
    logic [CH_CNT-1:0] ch_we;
    logic [31:0]       ch_rdata [CH_CNT];
    logic [31:0]       rd_mux;

    assign csr_i.awready = !aw_full_q;
    assign csr_i.wready  = !w_full_q;
    assign csr_i.bvalid  = bvalid_q;
    assign csr_i.bresp   = bresp_q;
    assign csr_i.arready = !rvalid_q;
    assign csr_i.rvalid  = rvalid_q;
    assign csr_i.rdata   = rdata_q;
    assign csr_i.rresp   = rresp_q;

    // A held write response blocks the next commit, keeping one write outstanding.
    assign commit = aw_full_q && w_full_q && !bvalid_q;
    assign ar_hs  = csr_i.arvalid && !rvalid_q;
    assign wr_dec = decode(aw_addr_q);
    assign rd_dec = decode(csr_i.araddr);

    always_comb begin
        ch_we  = '0;
        rd_mux = '0;
        for (int c = 0; c < CH_CNT; c++) begin
            ch_we[c] = commit && wr_dec.hit && (wr_dec.ch == 4'(c));
            if (rd_dec.ch == 4'(c)) rd_mux = ch_rdata[c];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            if (csr_i.awvalid && !aw_full_q) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= csr_i.awaddr;
            end else if (commit) begin
                aw_full_q <= 1'b0;
            end

            if (csr_i.wvalid && !w_full_q) begin
                w_full_q <= 1'b1;
                w_data_q <= csr_i.wdata;
                w_strb_q <= csr_i.wstrb;
            end else if (commit) begin
                w_full_q <= 1'b0;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_dec.hit ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && csr_i.bready) begin
                bvalid_q <= 1'b0;
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_dec.hit ? rd_mux : 32'h0;
                rresp_q  <= rd_dec.hit ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_q && csr_i.rready) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end
        end
    end

    for (genvar c = 0; c < CH_CNT; c++) begin : g_ch
        px_ss_csr_ch #(.CR_W(CR_W)) u_ch (
            .clk_i                (clk_i),
            .rst_i                (rst_i),
            .we                   (ch_we[c]),
            .wr_slot              (wr_dec.slot),
            .wdata                (w_data_q),
            .wstrb                (w_strb_q),
            .sof                  (sof_i[c]),
            .rd_slot              (rd_dec.slot),
            .rdata                (ch_rdata[c]),
            .px_to_skip           (px_to_skip_o[c*CR_W +: CR_W]),
            .px_skip_interval     (px_skip_interval_o[c*CR_W +: CR_W]),
            .add_px_skip_interval (add_px_skip_interval_o[c*CR_W +: CR_W]),
            .ln_to_skip           (ln_to_skip_o[c*CR_W +: CR_W]),
            .ln_skip_interval     (ln_skip_interval_o[c*CR_W +: CR_W]),
            .add_ln_skip_interval (add_ln_skip_interval_o[c*CR_W +: CR_W])
        );
    end

endmodule
